if_id_stage: RTL

- Fetch stage and IF/ID pipeline register of the pipelined RV32I core.
- Holds the program counter, drives the instruction-memory address, and captures the fetched word into the decode stage.
- Its InstD output is the instruction word consumed by decode-stage logic, including the immediate generator.
- Supports hazard-unit stalls, decode flush and execute-stage redirect (branch/jump).

---
 rtl/if_id_stage.sv | 84 ++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register of the pipelined RV32I core.
// Holds PCF, drives the instruction-memory address and captures the fetched word for decode.
module if_id_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic [31:0] ImemAddrF,
   input  logic [31:0] ImemRdataF,
   output logic [31:0] InstD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD
);

   localparam int unsigned XLEN = 32;

   logic [XLEN-1:0] pcf_q, pcf_d;
   logic [XLEN-1:0] inst_d_q, inst_d_d;
   logic [XLEN-1:0] pc_d_q, pc_d_d;
   logic [XLEN-1:0] pc_plus4_d_q, pc_plus4_d_d;
   logic            valid_d_q, valid_d_d;
   logic [XLEN-1:0] pc_plus4_f;

   assign pc_plus4_f = pcf_q + XLEN'(4);

   // Next-PC select: redirect beats stall; redirect target is forced word-aligned.
   always_comb begin
      pcf_d = pc_plus4_f;
      if (PCSrcE) begin
         pcf_d = {PCTargetE[XLEN-1:2], 2'b00};
      end else if (StallF) begin
         pcf_d = pcf_q;
      end
   end

   // IF/ID register next state: flush inserts a bubble even while stalled.
   always_comb begin
      inst_d_d     = inst_d_q;
      pc_d_d       = pc_d_q;
      pc_plus4_d_d = pc_plus4_d_q;
      valid_d_d    = valid_d_q;
      if (FlushD) begin
         inst_d_d     = NOP_INST;
         pc_d_d       = '0;
         pc_plus4_d_d = '0;
         valid_d_d    = 1'b0;
      end else if (!StallD) begin
         inst_d_d     = ImemRdataF;
         pc_d_d       = pcf_q;
         pc_plus4_d_d = pc_plus4_f;
         valid_d_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pcf_q        <= RESET_PC;
         inst_d_q     <= NOP_INST;
         pc_d_q       <= '0;
         pc_plus4_d_q <= '0;
         valid_d_q    <= 1'b0;
      end else begin
         pcf_q        <= pcf_d;
         inst_d_q     <= inst_d_d;
         pc_d_q       <= pc_d_d;
         pc_plus4_d_q <= pc_plus4_d_d;
         valid_d_q    <= valid_d_d;
      end
   end

   assign ImemAddrF = pcf_q;
   assign InstD     = inst_d_q;
   assign PCD       = pc_d_q;
   assign PCPlus4D  = pc_plus4_d_q;
   assign ValidD    = valid_d_q;

endmodule
